// File: rtl/digit_ctrl_pkg.sv
// Shared constants for the digit counter source stage feeding the 7-segment decoder.
package digit_ctrl_pkg;

    localparam int unsigned DIGIT_W        = 3;
    localparam int unsigned PRESCALE_W_DEF = 24;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/step_sync.sv
// Two-flop synchronizer for the step button followed by a rising-edge detector.
module step_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/digit_counter_ctrl.sv
// Prescaled up/down wrap counter with load and single-step button, driving the digit decoder.
module digit_counter_ctrl
    import digit_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
    parameter int unsigned DIGIT_W    = digit_ctrl_pkg::DIGIT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  load,
    input  logic [DIGIT_W-1:0]    load_value,
    input  logic [DIGIT_W-1:0]    max_value,
    input  logic [PRESCALE_W-1:0] compare_value,
    input  logic                  step_in,
    output logic [DIGIT_W-1:0]    counter,
    output logic                  tick,
    output logic                  wrap
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [DIGIT_W-1:0]    count_q, count_d;
    logic                  tick_q, wrap_q, wrap_d;
    logic                  tick_c, step_pulse, step_evt, advance;

    step_sync u_step_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (step_in),
        .rise_o  (step_pulse)
    );

    // >= so that lowering compare_value below the running count expires at once.
    always_comb begin
        tick_c  = 1'b0;
        presc_d = '0;
        if (enable) begin
            if (presc_q >= compare_value) begin
                tick_c = 1'b1;
            end else begin
                presc_d = presc_q + PRESCALE_W'(1);
            end
        end
    end

    assign step_evt = step_pulse & ~enable;
    assign advance  = tick_c | step_evt;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_value > max_value) ? max_value : load_value;
        end else if (advance) begin
            if (dir == DIR_UP) begin
                if (count_q >= max_value) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + DIGIT_W'(1);
                end
            end else begin
                // Out-of-range counts (max lowered underneath) re-enter at the top.
                if (count_q == '0 || count_q > max_value) begin
                    count_d = max_value;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - DIGIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_c;
            wrap_q  <= wrap_d;
        end
    end

    assign counter = count_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule
